mvm_stream_engine: RTL and testbench

Streaming fixed-point matrix-vector multiply engine for the RNN gate datapath. It computes y = W·x + b for an NROW×NCOL weight matrix using NROW/ROWS_PER_LANE time-multiplexed MAC lanes. The input vector streams in over a valid/ready handshake, and the weight columns come from an external synchronous RAM. The result is returned over a valid/ready handshake with optional saturation. It replaces the free-running dot-product unit in each gate. Key changes from that unit:

- explicit start/busy control
- bias addition
- full-precision accumulation
- back-pressure on the output

---
 rtl/rnn_fixed_pkg.sv | 43 ++++
 rtl/mac_lane.sv | 72 +++++++
 rtl/mvm_stream_engine.sv | 195 +++++++++++++++++++
 tb/tb_mvm_stream_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rnn_fixed_pkg.sv
// rtl/rnn_fixed_pkg.sv - shared fixed-point types and helpers for the RNN gate datapath
package rnn_fixed_pkg;

  localparam int QN_DEFAULT = 6;
  localparam int QM_DEFAULT = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_DRAIN,
    ST_DONE
  } mvm_state_t;

  // Total word width of a signed Q(qn.qm) value.
  function automatic int bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Clamps value into the signed range of 'width' bits when saturate is set.
  // Without saturation the value passes through and the caller keeps the low
  // 'width' bits, which gives two's-complement wrap.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input int width,
                                                   input logic saturate);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (saturate && (value > max_v)) return max_v;
    if (saturate && (value < min_v)) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one time-multiplexed multiply-accumulate lane with bias/shift/saturate finalize
module mac_lane
  import rnn_fixed_pkg::*;
#(
  parameter int BITWIDTH = 18,
  parameter int QM       = 11,
  parameter int ACC_W    = 41,
  parameter bit SATURATE = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       mac_en,
  input  logic                       last,
  input  logic signed [BITWIDTH-1:0] weight,
  input  logic signed [BITWIDTH-1:0] x,
  input  logic signed [BITWIDTH-1:0] bias,
  output logic                       fin,
  output logic signed [BITWIDTH-1:0] result
);

  localparam int PROD_W = 2 * BITWIDTH;

  logic signed [PROD_W-1:0] weight_ext;
  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  biased;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [63:0]       wide;
  logic signed [63:0]       clamped;
  logic [63-BITWIDTH:0]     unused_clamped_hi;

  // Full-precision signed product, sign-extended into the accumulator width.
  assign weight_ext = PROD_W'(weight);
  assign x_ext      = PROD_W'(x);
  assign prod       = weight_ext * x_ext;
  assign prod_ext   = ACC_W'(prod);

  // While fin is high the finished sum is being written back, so the next
  // pass starts from zero in the same cycle instead of losing a beat.
  assign acc_base = fin ? '0 : acc;
  assign acc_next = acc_base + (mac_en ? prod_ext : '0);

  // Bias is aligned to the product's 2*QM fraction, then one floor shift by QM.
  assign bias_ext = ACC_W'(bias) <<< QM;
  assign biased   = acc + bias_ext;
  assign shifted  = biased >>> QM;
  assign wide     = 64'(shifted);
  assign clamped  = sat_trunc(wide, BITWIDTH, SATURATE);
  assign result   = clamped[BITWIDTH-1:0];
  assign unused_clamped_hi = clamped[63:BITWIDTH];

  // Accumulator and finalize strobe; fin marks the cycle result is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      fin <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      fin <= 1'b0;
    end else begin
      acc <= acc_next;
      fin <= mac_en & last;
    end
  end

endmodule

// File: rtl/mvm_stream_engine.sv
// rtl/mvm_stream_engine.sv - streaming fixed-point y = W*x + b engine with start/busy control
module mvm_stream_engine
  import rnn_fixed_pkg::*;
#(
  parameter int NROW          = 16,
  parameter int NCOL          = 16,
  parameter int QN            = QN_DEFAULT,
  parameter int QM            = QM_DEFAULT,
  parameter int ROWS_PER_LANE = 2,
  parameter bit SATURATE      = 1'b1,
  localparam int BITWIDTH     = bitwidth(QN, QM),
  localparam int N_LANE       = NROW / ROWS_PER_LANE,
  localparam int ACC_W        = 2 * BITWIDTH + clog2(NCOL) + 1,
  localparam int ADDR_W       = clog2(NCOL),
  localparam int SEL_W        = (clog2(ROWS_PER_LANE) > 1) ? clog2(ROWS_PER_LANE) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  input  logic [BITWIDTH-1:0]      x_data,
  input  logic                     x_valid,
  output logic                     x_ready,
  output logic [ADDR_W-1:0]        col_addr,
  output logic [SEL_W-1:0]         row_sel,
  input  logic [BITWIDTH*NROW-1:0] weight_col,
  input  logic [BITWIDTH*NROW-1:0] bias,
  output logic [BITWIDTH*NROW-1:0] y_data,
  output logic                     y_valid,
  input  logic                     y_ready
);

  mvm_state_t                 state;
  logic [ADDR_W-1:0]          idx;
  logic                       drain_cnt;
  logic signed [BITWIDTH-1:0] x_buf [NCOL];

  logic                       idx_last;
  logic                       last_col;
  logic                       last_sel;
  logic                       clear_acc;
  logic                       x_fire;

  logic                       s1_valid;
  logic                       s1_last;
  logic [ADDR_W-1:0]          s1_col;
  logic [SEL_W-1:0]           s1_sel;
  logic [SEL_W-1:0]           s2_sel;

  logic [N_LANE-1:0]          lane_fin;
  logic signed [BITWIDTH-1:0] lane_result [N_LANE];

  assign idx_last  = (idx == ADDR_W'(NCOL - 1));
  assign last_col  = (col_addr == ADDR_W'(NCOL - 1));
  assign last_sel  = (row_sel == SEL_W'(ROWS_PER_LANE - 1));
  assign clear_acc = (state == ST_IDLE) && start;
  assign x_fire    = (state == ST_LOAD) && x_valid && x_ready;

  // Control FSM: load x, sweep row_sel (outer) by col_addr (inner), drain, hold result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      x_ready   <= 1'b0;
      y_valid   <= 1'b0;
      idx       <= '0;
      col_addr  <= '0;
      row_sel   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_LOAD;
            busy    <= 1'b1;
            x_ready <= 1'b1;
            idx     <= '0;
          end
        end
        ST_LOAD: begin
          if (x_fire) begin
            idx <= idx_last ? '0 : idx + 1'b1;
            if (idx_last) begin
              state    <= ST_CALC;
              x_ready  <= 1'b0;
              col_addr <= '0;
              row_sel  <= '0;
            end
          end
        end
        ST_CALC: begin
          col_addr <= last_col ? '0 : col_addr + 1'b1;
          if (last_col) begin
            row_sel <= last_sel ? '0 : row_sel + 1'b1;
            if (last_sel) begin
              state     <= ST_DRAIN;
              drain_cnt <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            state   <= ST_DONE;
            y_valid <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_DONE: begin
          if (y_ready) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            y_valid <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          x_ready <= 1'b0;
          y_valid <= 1'b0;
        end
      endcase
    end
  end

  // Input vector buffer, written in arrival order during LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCOL; i++) x_buf[i] <= '0;
    end else if (x_fire) begin
      x_buf[idx] <= x_data;
    end
  end

  // Delay the issued address by the RAM read (s1) and the MAC stage (s2).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_col   <= '0;
      s1_sel   <= '0;
      s2_sel   <= '0;
    end else begin
      s1_valid <= (state == ST_CALC);
      s1_last  <= (state == ST_CALC) && last_col;
      s1_col   <= col_addr;
      s1_sel   <= row_sel;
      s2_sel   <= s1_sel;
    end
  end

  generate
    for (genvar l = 0; l < N_LANE; l++) begin : g_lane
      logic signed [BITWIDTH-1:0] lane_bias;
      assign lane_bias = bias[(l * ROWS_PER_LANE + int'(s2_sel)) * BITWIDTH +: BITWIDTH];

      mac_lane #(
        .BITWIDTH(BITWIDTH),
        .QM      (QM),
        .ACC_W   (ACC_W),
        .SATURATE(SATURATE)
      ) u_lane (
        .clk   (clk),
        .reset (reset),
        .clear (clear_acc),
        .mac_en(s1_valid),
        .last  (s1_last),
        .weight(weight_col[l * BITWIDTH +: BITWIDTH]),
        .x     (x_buf[s1_col]),
        .bias  (lane_bias),
        .fin   (lane_fin[l]),
        .result(lane_result[l])
      );
    end

    if (N_LANE < NROW) begin : g_unused_weight
      logic unused_weight_hi;
      assign unused_weight_hi = ^weight_col[BITWIDTH*NROW-1:BITWIDTH*N_LANE];
    end
  endgenerate

  // Result write-back: each finishing lane lands in the row selected by the delayed row_sel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_data <= '0;
    end else begin
      for (int l = 0; l < N_LANE; l++) begin
        if (lane_fin[l]) begin
          y_data[(l * ROWS_PER_LANE + int'(s2_sel)) * BITWIDTH +: BITWIDTH] <= lane_result[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_mvm_stream_engine.sv
// tb/tb_mvm_stream_engine.sv - directed self-checking bench for mvm_stream_engine
module tb_mvm_stream_engine;

  localparam int NROW  = 16;
  localparam int NCOL  = 16;
  localparam int BW    = 18;
  localparam int RPL   = 2;
  localparam int NLANE = NROW / RPL;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic x_valid = 1'b0;
  logic y_ready = 1'b0;
  logic [BW-1:0] x_data = '0;
  logic [BW*NROW-1:0] weight_col = '0;
  logic [BW*NROW-1:0] bias = '0;

  logic busy, x_ready, y_valid;
  logic [3:0] col_addr;
  logic [0:0] row_sel;
  logic [BW*NROW-1:0] y_data;

  logic w_busy, w_x_ready, w_y_valid;
  logic [3:0] w_col_addr;
  logic [0:0] w_row_sel;
  logic [BW*NROW-1:0] w_y_data;

  int checks = 0;
  int errors = 0;
  int w_mem [NROW][NCOL];
  int x_vec [NCOL];
  int exp_y [NROW];
  int lat;

  always #5 clk = ~clk;

  mvm_stream_engine #(.SATURATE(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .col_addr(col_addr), .row_sel(row_sel), .weight_col(weight_col),
    .bias(bias), .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  mvm_stream_engine #(.SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .busy(w_busy),
    .x_data(x_data), .x_valid(x_valid), .x_ready(w_x_ready),
    .col_addr(w_col_addr), .row_sel(w_row_sel), .weight_col(weight_col),
    .bias(bias), .y_data(w_y_data), .y_valid(w_y_valid), .y_ready(y_ready)
  );

  // Synchronous weight RAM with one cycle read latency, one column slice per lane.
  always @(posedge clk) begin
    for (int l = 0; l < NLANE; l++)
      weight_col[l*BW +: BW] <= BW'(w_mem[l*RPL + int'(row_sel)][col_addr]);
  end

  task automatic chk(input string tag, input integer obs, input integer exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic integer y_at(input int r);
    logic signed [BW-1:0] s;
    s = y_data[r*BW +: BW];
    return s;
  endfunction

  function automatic integer yw_at(input int r);
    logic signed [BW-1:0] s;
    s = w_y_data[r*BW +: BW];
    return s;
  endfunction

  task automatic set_bias_const(input int v);
    for (int r = 0; r < NROW; r++) bias[r*BW +: BW] = BW'(v);
  endtask

  task automatic set_w_const(input int v);
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++) w_mem[r][c] = v;
  endtask

  task automatic set_x_const(input int v);
    for (int c = 0; c < NCOL; c++) x_vec[c] = v;
  endtask

  task automatic check_y(input string tag);
    for (int r = 0; r < NROW; r++)
      chk($sformatf("%s_y%0d", tag, r), y_at(r), exp_y[r]);
  endtask

  task automatic check_y_wrap(input string tag);
    for (int r = 0; r < NROW; r++)
      chk($sformatf("%s_wrap_y%0d", tag, r), yw_at(r), exp_y[r]);
  endtask

  task automatic start_and_load(input bit gaps);
    int waits;
    waits = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < NCOL; i++) begin
      if (gaps && (i % 3 == 1)) begin
        x_valid = 1'b0;
        repeat (1 + i % 2) @(posedge clk);
        #1;
      end
      x_valid = 1'b1;
      x_data  = BW'(x_vec[i]);
      while (!x_ready && waits < 50) begin
        @(posedge clk); #1;
        waits++;
      end
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    chk("x_ready_stall", waits, 0);
  endtask

  task automatic run_product(input bit gaps, input bit start_in_calc, output int latency);
    start_and_load(gaps);
    latency = 0;
    while (!y_valid && latency < 200) begin
      start = (start_in_calc && latency == 4);
      @(posedge clk); #1;
      latency++;
    end
    start = 1'b0;
  endtask

  task automatic accept_y(input string tag);
    y_ready = 1'b1;
    @(posedge clk); #1;
    y_ready = 1'b0;
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_yvalid_after"}, y_valid, 0);
  endtask

  initial begin
    set_w_const(0);
    set_x_const(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_x_ready", x_ready, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", integer'(|y_data), 0);
    chk("rst_col_addr", col_addr, 0);
    chk("rst_row_sel", row_sel, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // identity
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++) w_mem[r][c] = (r == c) ? 2048 : 0;
    set_x_const(2048);
    set_bias_const(0);
    run_product(1'b0, 1'b0, lat);
    chk("ident_latency", lat, 34);
    for (int r = 0; r < NROW; r++) exp_y[r] = 2048;
    check_y("ident");
    accept_y("ident");
    chk("ident_hold_idle", y_at(7), 2048);

    // row ordering
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++) w_mem[r][c] = r * 128;
    run_product(1'b0, 1'b0, lat);
    chk("rows_latency", lat, 34);
    for (int r = 0; r < NROW; r++) exp_y[r] = r * 2048;
    check_y("rows");
    accept_y("rows");

    // bias and sign
    set_w_const(2048);
    set_x_const(-1024);
    set_bias_const(512);
    run_product(1'b0, 1'b0, lat);
    for (int r = 0; r < NROW; r++) exp_y[r] = -15872;
    check_y("bias");
    accept_y("bias");

    set_bias_const(0);
    set_x_const(0);
    x_vec[0] = -1;
    run_product(1'b0, 1'b0, lat);
    for (int r = 0; r < NROW; r++) exp_y[r] = -1;
    check_y("neg_lsb");
    accept_y("neg_lsb");

    set_w_const(1);
    run_product(1'b0, 1'b0, lat);
    check_y("floor");
    accept_y("floor");

    // saturation against wrap
    set_w_const(63488);
    set_x_const(63488);
    run_product(1'b0, 1'b0, lat);
    for (int r = 0; r < NROW; r++) exp_y[r] = 131071;
    check_y("sat_pos");
    for (int r = 0; r < NROW; r++) exp_y[r] = 32768;
    check_y_wrap("sat_pos");
    accept_y("sat_pos");

    set_x_const(-63488);
    run_product(1'b0, 1'b0, lat);
    for (int r = 0; r < NROW; r++) exp_y[r] = -131072;
    check_y("sat_neg");
    for (int r = 0; r < NROW; r++) exp_y[r] = -32768;
    check_y_wrap("sat_neg");
    accept_y("sat_neg");

    // handshakes: x_valid gaps, start during CALC, output back-pressure
    set_w_const(2048);
    for (int c = 0; c < NCOL; c++) x_vec[c] = c * 64;
    for (int r = 0; r < NROW; r++) bias[r*BW +: BW] = BW'(r * 16);
    run_product(1'b1, 1'b1, lat);
    chk("hs_latency", lat, 34);
    for (int r = 0; r < NROW; r++) exp_y[r] = 7680 + 16 * r;
    check_y("hs");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hs_stall%0d_valid", k), y_valid, 1);
      chk($sformatf("hs_stall%0d_y0", k), y_at(0), 7680);
      chk($sformatf("hs_stall%0d_y15", k), y_at(15), 7920);
    end
    accept_y("hs");

    // reset in the middle of CALC
    set_bias_const(0);
    set_x_const(2048);
    start_and_load(1'b0);
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_x_ready", x_ready, 0);
    chk("mid_rst_y_valid", y_valid, 0);
    chk("mid_rst_y_data", integer'(|y_data), 0);
    chk("mid_rst_col_addr", col_addr, 0);
    chk("mid_rst_row_sel", row_sel, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++) w_mem[r][c] = (r == c) ? 2048 : 0;
    run_product(1'b0, 1'b0, lat);
    chk("post_rst_latency", lat, 34);
    for (int r = 0; r < NROW; r++) exp_y[r] = 2048;
    check_y("post_rst");
    accept_y("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
